// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display: active-low 7-segment codes {g,f,e,d,c,b,a},
// decoder input codes and the digit scan state encoding.
package clock_disp_pkg;

  localparam logic [6:0] SegDigit0 = 7'h40;
  localparam logic [6:0] SegDigit1 = 7'h79;
  localparam logic [6:0] SegDigit2 = 7'h24;
  localparam logic [6:0] SegDigit3 = 7'h30;
  localparam logic [6:0] SegDigit4 = 7'h19;
  localparam logic [6:0] SegDigit5 = 7'h12;
  localparam logic [6:0] SegDigit6 = 7'h02;
  localparam logic [6:0] SegDigit7 = 7'h78;
  localparam logic [6:0] SegDigit8 = 7'h00;
  localparam logic [6:0] SegDigit9 = 7'h10;
  localparam logic [6:0] SegA      = 7'h08;
  localparam logic [6:0] SegP      = 7'h0C;
  localparam logic [6:0] SegBlank  = 7'h7F;

  localparam logic [3:0] CodeA     = 4'd10;
  localparam logic [3:0] CodeP     = 4'd11;
  localparam logic [3:0] CodeBlank = 4'd15;

  typedef enum logic [1:0] {
    ScanD0 = 2'd0,
    ScanD1 = 2'd1,
    ScanD2 = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low segment decoder: 0..9, 10='A', 11='P', others blank.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SegBlank;
    case (code)
      4'd0:    seg_n = SegDigit0;
      4'd1:    seg_n = SegDigit1;
      4'd2:    seg_n = SegDigit2;
      4'd3:    seg_n = SegDigit3;
      4'd4:    seg_n = SegDigit4;
      4'd5:    seg_n = SegDigit5;
      4'd6:    seg_n = SegDigit6;
      4'd7:    seg_n = SegDigit7;
      4'd8:    seg_n = SegDigit8;
      4'd9:    seg_n = SegDigit9;
      CodeA:   seg_n = SegA;
      CodeP:   seg_n = SegP;
      default: seg_n = SegBlank;
    endcase
  end

endmodule

// File: rtl/hour_display_driver.sv
// Multiplexed 3-digit hour + AM/PM display driver fed from an asynchronous 1 Hz hour counter.
// Each digit slot opens with one blanking cycle to avoid ghosting between digits.
module hour_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter logic        PM_AT_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hour_q,
  input  logic       hour_roll,
  output logic       pm,
  output logic [6:0] seg_n,
  output logic [2:0] an_n
);
  import clock_disp_pkg::*;

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [3:0]      hour_s1_q, hour_s2_q, hour_prev_q;
  logic [3:0]      hour_disp_q, hour_disp_d;
  logic            roll_s1_q, roll_s2_q, roll_prev_q;
  logic            pm_q, pm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  scan_state_e     state_q, state_d;
  logic [2:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic [3:0]      tens_code, units_code, dig_code;
  logic [6:0]      dig_seg;

  seg7_decode u_seg7_decode (
    .code  (dig_code),
    .seg_n (dig_seg)
  );

  always_comb begin
    // Accept a synchronized hour only once it has held for two samples (multi-bit CDC).
    hour_disp_d = hour_disp_q;
    if ((hour_s2_q == hour_prev_q) && (hour_s2_q < 4'd12)) begin
      hour_disp_d = hour_s2_q;
    end
    pm_d = pm_q ^ (roll_s2_q & ~roll_prev_q);

    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      unique case (state_q)
        ScanD0:  state_d = ScanD1;
        ScanD1:  state_d = ScanD2;
        default: state_d = ScanD0;
      endcase
    end

    if (hour_disp_q == 4'd0) begin
      tens_code  = 4'd1;
      units_code = 4'd2;
    end else if (hour_disp_q < 4'd10) begin
      tens_code  = CodeBlank;
      units_code = hour_disp_q;
    end else begin
      tens_code  = 4'd1;
      units_code = hour_disp_q - 4'd10;
    end

    unique case (state_q)
      ScanD0:  dig_code = pm_q ? CodeP : CodeA;
      ScanD1:  dig_code = units_code;
      ScanD2:  dig_code = tens_code;
      default: dig_code = CodeBlank;
    endcase

    an_n_d  = 3'b111;
    seg_n_d = SegBlank;
    if ((cnt_q != '0) && (dig_code != CodeBlank)) begin
      seg_n_d = dig_seg;
      unique case (state_q)
        ScanD0:  an_n_d = 3'b110;
        ScanD1:  an_n_d = 3'b101;
        ScanD2:  an_n_d = 3'b011;
        default: an_n_d = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hour_s1_q   <= '0;
      hour_s2_q   <= '0;
      hour_prev_q <= '0;
      hour_disp_q <= '0;
      roll_s1_q   <= 1'b0;
      roll_s2_q   <= 1'b0;
      roll_prev_q <= 1'b0;
      pm_q        <= PM_AT_RESET;
      cnt_q       <= '0;
      state_q     <= ScanD0;
      an_n_q      <= 3'b111;
      seg_n_q     <= SegBlank;
    end else begin
      hour_s1_q   <= hour_q;
      hour_s2_q   <= hour_s1_q;
      hour_prev_q <= hour_s2_q;
      hour_disp_q <= hour_disp_d;
      roll_s1_q   <= hour_roll;
      roll_s2_q   <= roll_s1_q;
      roll_prev_q <= roll_s2_q;
      pm_q        <= pm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
    end
  end

  assign pm    = pm_q;
  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_hour_display_driver.sv
// Directed bench for hour_display_driver with a 4-cycle refresh slot.
module tb_hour_display_driver;

  logic       clk;
  logic       reset;
  logic [3:0] hour_q;
  logic       hour_roll;
  logic       pm;
  logic [6:0] seg_n;
  logic [2:0] an_n;

  int checks   = 0;
  int failures = 0;

  hour_display_driver #(
    .REFRESH_DIV (4),
    .PM_AT_RESET (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hour_q    (hour_q),
    .hour_roll (hour_roll),
    .pm        (pm),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] hour;
    logic [2:0] an;
    logic [6:0] seg;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wait (sampling on negedge) until an_n shows the requested slot, within a cycle budget.
  task automatic wait_slot(input logic [2:0] an, input int budget, input string name,
                           output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (an_n === an) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: slot an_n=%b not seen within %0d cycles", name, an, budget);
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic ok;
    int   lows;
    int   toggles;
    int   seen;
    logic pm_prev;

    vecs[0] = '{4'd0,  3'b011, 7'h79, "h0_tens"};
    vecs[1] = '{4'd0,  3'b101, 7'h24, "h0_units"};
    vecs[2] = '{4'd0,  3'b110, 7'h08, "h0_am"};
    vecs[3] = '{4'd7,  3'b101, 7'h78, "h7_units"};
    vecs[4] = '{4'd5,  3'b101, 7'h12, "h5_units"};
    vecs[5] = '{4'd9,  3'b101, 7'h10, "h9_units"};
    vecs[6] = '{4'd11, 3'b011, 7'h79, "h11_tens"};
    vecs[7] = '{4'd11, 3'b101, 7'h79, "h11_units"};

    reset     = 1'b1;
    hour_q    = 4'd0;
    hour_roll = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", {29'd0, an_n}, 32'h7);
    check("rst_seg", {25'd0, seg_n}, 32'h7F);
    check("rst_pm", {31'd0, pm}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_blank_an", {29'd0, an_n}, 32'h7);
    @(negedge clk);
    check("rel_first_an", {29'd0, an_n}, 32'h6);
    check("rel_first_seg", {25'd0, seg_n}, 32'h08);

    foreach (vecs[k]) begin
      hour_q = vecs[k].hour;
      repeat (8) @(negedge clk);
      wait_slot(vecs[k].an, 16, vecs[k].name, ok);
      if (ok) check(vecs[k].name, {25'd0, seg_n}, {25'd0, vecs[k].seg});
    end

    // Blank tens: hour 7 must never light digit 2 across three scans.
    hour_q = 4'd7;
    repeat (8) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (an_n[2] !== 1'b1) lows++;
      if (an_n[2] === 1'b1 && an_n[1] === 1'b1 && an_n[0] === 1'b1 && seg_n !== 7'h7F) lows++;
    end
    check("h7_tens_dark", lows, 0);

    // Rollover: pm flips on the third edge only, then holds while hour_roll stays high.
    hour_roll = 1'b1;
    @(negedge clk);
    check("roll_e1_pm", {31'd0, pm}, 32'h0);
    @(negedge clk);
    check("roll_e2_pm", {31'd0, pm}, 32'h0);
    @(negedge clk);
    check("roll_e3_pm", {31'd0, pm}, 32'h1);
    toggles = 0;
    pm_prev = pm;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (pm !== pm_prev) toggles++;
      pm_prev = pm;
    end
    check("roll_once", toggles, 0);
    hour_roll = 1'b0;
    wait_slot(3'b110, 16, "pm_slot", ok);
    if (ok) check("pm_seg", {25'd0, seg_n}, 32'h0C);
    hour_roll = 1'b1;
    repeat (5) @(negedge clk);
    hour_roll = 1'b0;
    repeat (3) @(negedge clk);
    check("roll2_pm", {31'd0, pm}, 32'h0);

    // Out-of-range hour is ignored.
    hour_q = 4'd10;
    repeat (8) @(negedge clk);
    hour_q = 4'd13;
    repeat (12) @(negedge clk);
    wait_slot(3'b011, 16, "h13_tens_slot", ok);
    if (ok) check("h13_tens", {25'd0, seg_n}, 32'h79);
    wait_slot(3'b101, 16, "h13_units_slot", ok);
    if (ok) check("h13_units", {25'd0, seg_n}, 32'h40);

    // Unsettled hour (changing every cycle) must never be captured.
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      hour_q = (i % 2 == 0) ? 4'd3 : 4'd5;
      @(negedge clk);
      if (i > 6 && an_n === 3'b101) begin
        seen++;
        check("toggle_units", {25'd0, seg_n}, 32'h40);
      end
    end
    check("toggle_seen", {31'd0, seen > 0}, 32'h1);

    // Mid-scan reset during a lit D2 slot with pm=1.
    hour_q = 4'd0;
    hour_roll = 1'b1;
    repeat (6) @(negedge clk);
    hour_roll = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_pm", {31'd0, pm}, 32'h1);
    wait_slot(3'b011, 16, "mid_d2_slot", ok);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_an", {29'd0, an_n}, 32'h7);
    check("mid_rst_seg", {25'd0, seg_n}, 32'h7F);
    check("mid_rst_pm", {31'd0, pm}, 32'h0);
    @(negedge clk);
    check("mid_blank_an", {29'd0, an_n}, 32'h7);
    @(negedge clk);
    check("mid_d0_an", {29'd0, an_n}, 32'h6);
    check("mid_d0_seg", {25'd0, seg_n}, 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
